ext_mem_arbiter: RTL and testbench
==================================

# ext_mem_arbiter

Round-robin arbiter that shares one external memory port between up to `NUM_REQ` effect requesters (delay, future looper/reverb) in the pedalboard. Each requester issues single-word read or write transactions with a hold-until-ack handshake. The arbiter serialises them onto the memory side and returns read data. A per-transaction watchdog keeps a stalled memory from freezing the audio chain.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `AWIDTH`, 24, word address width
- `DWIDTH`, 16, data width
- `TIMEOUT`, 255, max cycles waiting for `mem_ack_i` before abort (≥2)

- `clk_i`  in  1  system clock; the only clock
- `arst_n_i`  in  1  reset, asynchronous, active-low
- `req_i`  in  NUM_REQ  per-requester transaction request
- `we_i`  in  NUM_REQ  1 = write, 0 = read
- `addr_i`  in  NUM_REQ×AWIDTH  per-requester address
- `wdata_i`  in  NUM_REQ×DWIDTH  per-requester write data
- `ack_o`  out  NUM_REQ  one-cycle completion pulse to granted requester
- `rdata_o`  out  DWIDTH  read data, shared, valid while `ack_o` is high
- `err_o`  out  1  high with `ack_o` when the transaction timed out
- `mem_req_o`  out  1  memory command valid
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  AWIDTH  memory address
- `mem_wdata_o`  out  DWIDTH  memory write data
- `mem_ack_i`  in  1  one-cycle memory completion; read data valid this cycle
- `mem_rdata_i`  in  DWIDTH  memory read data
- `timeout_cnt_o`  out  8  saturating count of timed-out transactions
- `busy_o`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: scan `req_i` starting at index `ptr` and wrap modulo NUM_REQ. The first asserted index is granted. Register `g`, and latch `we`, `addr` and `wdata` of `g` into the `mem_*_o` registers. Set `mem_req_o`, set `ptr <= (g+1) mod NUM_REQ`, then go to BUSY. If no request is asserted, stay in IDLE and leave `ptr` unchanged.
- BUSY: hold `mem_req_o` and all command outputs stable. The watchdog counter starts at 0 on entry and increments each cycle.
  - On `mem_ack_i`: capture `mem_rdata_i` into `rdata_o`, but only when the transaction is a read. Drop `mem_req_o` and go to RESP with `err=0`.
  - When the counter reaches `TIMEOUT-1` and `mem_ack_i` is low: set `rdata_o=0`, drop `mem_req_o`, go to RESP with `err=1`, and increment `timeout_cnt_o`, saturating at 255.
  - If `mem_ack_i` arrives in the cycle where the counter equals `TIMEOUT-1`, the ack wins and no error is flagged.
- RESP: `ack_o[g]=1` and `err_o=err` for exactly one cycle, then go to IDLE.
- `mem_ack_i` is ignored outside BUSY. A late ack for an aborted transaction is dropped.
- Requester rules:
  - Hold `req_i[k]`, `we_i[k]`, `addr_i[k]` and `wdata_i[k]` stable from assertion until `ack_o[k]`.
  - Deassert `req_i[k]` in the cycle after `ack_o[k]`. If `req_i[k]` is still high in that cycle, it is a new request.
  - A requester must not withdraw a request before its ack. If it does, the behaviour is undefined.
- `rdata_o` holds its last value outside RESP. After a write it is unchanged.
- Reset (`arst_n_i` low), asynchronous and effective immediately, including in the middle of a transaction:
  - state goes to IDLE, `ptr` to 0 and the watchdog counter to 0;
  - all outputs go to 0: `ack_o`, `rdata_o`, `err_o`, `mem_*_o`, `timeout_cnt_o` and `busy_o`.
- Reset release is synchronous-safe: it is the integrator's job to deassert reset synchronously to `clk_i`.

## Timing
- A request sampled in IDLE in cycle 0 puts `mem_req_o=1` in cycle 1.
- `mem_ack_i` may arrive as early as cycle 1. An ack in cycle N gives `ack_o` in cycle N+1, and the FSM is back in IDLE in cycle N+2.
- Minimum transaction is 3 cycles. Back-to-back transactions start every 3 cycles at best.
- For a timed-out transaction, `ack_o`/`err_o` fire `TIMEOUT+1` cycles after `mem_req_o` rises.
- Fairness: with all NUM_REQ requesters continuously active, each is granted once in every NUM_REQ grants.
- `busy_o` is registered and high from cycle 1 through the RESP cycle.

## Test plan
- **Single read:** requester 0 reads address 0x000123 while memory acks after 4 cycles with 0xBEEF. Require:
  - `mem_req_o` high in cycles 1–4, with `mem_addr_o=0x000123` and `mem_we_o=0`;
  - `ack_o=2'b01` and `rdata_o=0xBEEF` in cycle 5;
  - `err_o=0`.
- **Round-robin:** both requesters assert continuously from reset and memory acks in 1 cycle. Require grants in the order 0,1,0,1,…, with a new `mem_req_o` rising every 3 cycles.
- **Timeout:** with `TIMEOUT=8`, memory never acks a read. Require:
  - `mem_req_o` high for exactly 8 cycles;
  - `ack_o` and `err_o` high together in cycle 9, with `rdata_o=0`;
  - `timeout_cnt_o=1`;
  - a late `mem_ack_i` in cycle 12 produces no `ack_o`.
- **Ack on deadline:** with `TIMEOUT=8`, memory acks in the 8th BUSY cycle. Require `err_o=0`, `timeout_cnt_o` unchanged and `rdata_o` equal to the memory data.
- **Write:** requester 1 writes 0x1234 to address 0x00ABCD. Require `mem_we_o=1` and `mem_wdata_o=0x1234` while `mem_req_o` is high, and `rdata_o` unchanged after `ack_o=2'b10`.
- **Mid-transaction reset:** pulse `arst_n_i` low during BUSY, asynchronously to `clk_i`. Require:
  - all outputs 0 immediately;
  - after release, a pending request from requester 1 is granted before requester 0, since `ptr` is back at 0 and requester 0 is idle.

Source files
------------

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin sharing of one external memory port between
// NUM_REQ effect requesters, with a per-transaction watchdog so a stalled
// memory cannot freeze the audio chain.
module ext_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AWIDTH  = 24,
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                             clk_i,
  input  logic                             arst_n_i,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ-1:0][AWIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]               ack_o,
  output logic [DWIDTH-1:0]                rdata_o,
  output logic                             err_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [AWIDTH-1:0]                mem_addr_o,
  output logic [DWIDTH-1:0]                mem_wdata_o,
  input  logic                             mem_ack_i,
  input  logic [DWIDTH-1:0]                mem_rdata_i,
  output logic [7:0]                       timeout_cnt_o,
  output logic                             busy_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Memory command latched at grant and held for the whole BUSY phase.
  typedef struct packed {
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
  } mem_cmd_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;
  logic [CW-1:0] wd_cnt;
  mem_cmd_t      cmd;

  logic          pick_vld;
  logic [PW-1:0] pick;
  logic [PW-1:0] pick_nxt;

  assign mem_we_o    = cmd.we;
  assign mem_addr_o  = cmd.addr;
  assign mem_wdata_o = cmd.wdata;

  // Round-robin scan from ptr: walk offsets high to low so the lowest
  // offset (closest to ptr) is the one left standing.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req_i[idx]) begin
        pick_vld = 1'b1;
        pick     = PW'(idx);
      end
    end
    pick_nxt = PW'((int'(pick) + 1) % NUM_REQ);
  end

  // Arbiter FSM with all outputs registered; ack/err are single-cycle pulses.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state         <= IDLE;
      ptr           <= '0;
      g             <= '0;
      wd_cnt        <= '0;
      cmd           <= '0;
      mem_req_o     <= 1'b0;
      ack_o         <= '0;
      err_o         <= 1'b0;
      rdata_o       <= '0;
      timeout_cnt_o <= '0;
      busy_o        <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            g         <= pick;
            cmd       <= '{we: we_i[pick], addr: addr_i[pick], wdata: wdata_i[pick]};
            mem_req_o <= 1'b1;
            ptr       <= pick_nxt;
            wd_cnt    <= '0;
            busy_o    <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Ack beats the watchdog when both land in the same cycle.
          if (mem_ack_i) begin
            if (!cmd.we) rdata_o <= mem_rdata_i;
            mem_req_o <= 1'b0;
            ack_o     <= NUM_REQ'(1) << g;
            err_o     <= 1'b0;
            state     <= RESP;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            rdata_o   <= '0;
            mem_req_o <= 1'b0;
            ack_o     <= NUM_REQ'(1) << g;
            err_o     <= 1'b1;
            if (timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'd1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter (2 requesters, TIMEOUT=8).
// Cycle numbering: the period after a posedge; inputs driven and outputs
// sampled 1ns after the edge.
module tb_ext_mem_arbiter;

  localparam int NR = 2;
  localparam int AW = 24;
  localparam int DW = 16;

  logic                 clk_i = 1'b0;
  logic                 arst_n_i;
  logic [NR-1:0]        req_i, we_i;
  logic [NR-1:0][AW-1:0] addr_i;
  logic [NR-1:0][DW-1:0] wdata_i;
  logic [NR-1:0]        ack_o;
  logic [DW-1:0]        rdata_o;
  logic                 err_o, mem_req_o, mem_we_o, mem_ack_i, busy_o;
  logic [AW-1:0]        mem_addr_o;
  logic [DW-1:0]        mem_wdata_o, mem_rdata_i;
  logic [7:0]           timeout_cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  ext_mem_arbiter #(.NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .timeout_cnt_o(timeout_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every output must read zero while reset is applied.
  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},  32'(ack_o), 0);
    chk({tag, "_rd"},   32'(rdata_o), 0);
    chk({tag, "_err"},  32'(err_o), 0);
    chk({tag, "_mreq"}, 32'(mem_req_o), 0);
    chk({tag, "_mwe"},  32'(mem_we_o), 0);
    chk({tag, "_madr"}, 32'(mem_addr_o), 0);
    chk({tag, "_mwd"},  32'(mem_wdata_o), 0);
    chk({tag, "_tcnt"}, 32'(timeout_cnt_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    int last, ngr, exp_g;
    arst_n_i = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    // ---- reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("rst");
    arst_n_i = 1'b1;

    // ---- single read, req 0, memory acks in cycle 4
    req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 24'h000123;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("rd_mreq", 32'(mem_req_o), 1);
      chk("rd_addr", 32'(mem_addr_o), 32'h000123);
      chk("rd_we",   32'(mem_we_o), 0);
      chk("rd_noack", 32'(ack_o), 0);
      if (c == 4) begin mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF; end
    end
    tick();
    mem_ack_i = 1'b0;
    chk("rd_ack",   32'(ack_o), 32'b01);
    chk("rd_data",  32'(rdata_o), 32'hBEEF);
    chk("rd_err",   32'(err_o), 0);
    chk("rd_busy",  32'(busy_o), 1);
    chk("rd_mreq0", 32'(mem_req_o), 0);
    req_i[0] = 1'b0;
    tick();
    chk("rd_ack_pulse", 32'(ack_o), 0);
    chk("rd_idle", 32'(busy_o), 0);

    // ---- write, req 1; memory data on the bus must not be captured
    req_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = 24'h00ABCD; wdata_i[1] = 16'h1234;
    tick();
    chk("wr_mreq", 32'(mem_req_o), 1);
    chk("wr_we",   32'(mem_we_o), 1);
    chk("wr_wd",   32'(mem_wdata_o), 32'h1234);
    chk("wr_addr", 32'(mem_addr_o), 32'h00ABCD);
    mem_ack_i = 1'b1; mem_rdata_i = 16'h5555;
    tick();
    mem_ack_i = 1'b0;
    chk("wr_ack",  32'(ack_o), 32'b10);
    chk("wr_rd",   32'(rdata_o), 32'hBEEF);
    chk("wr_err",  32'(err_o), 0);
    req_i[1] = 1'b0; we_i[1] = 1'b0;
    tick();

    // ---- timeout: read never acked
    req_i[0] = 1'b1; addr_i[0] = 24'h000042;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("to_mreq", 32'(mem_req_o), 1);
      chk("to_noack", 32'(ack_o), 0);
    end
    tick();
    chk("to_mreq0", 32'(mem_req_o), 0);
    chk("to_ack",  32'(ack_o), 32'b01);
    chk("to_err",  32'(err_o), 1);
    chk("to_rd",   32'(rdata_o), 0);
    chk("to_tcnt", 32'(timeout_cnt_o), 1);
    req_i[0] = 1'b0;
    tick(); tick(); tick();
    mem_ack_i = 1'b1; mem_rdata_i = 16'h7777;
    tick();
    mem_ack_i = 1'b0;
    chk("late_ack", 32'(ack_o), 0);
    chk("late_busy", 32'(busy_o), 0);
    chk("late_rd", 32'(rdata_o), 0);

    // ---- ack exactly on the deadline (8th BUSY cycle)
    req_i[0] = 1'b1; addr_i[0] = 24'h000077;
    for (int c = 1; c <= 8; c++) tick();
    chk("dl_mreq", 32'(mem_req_o), 1);
    mem_ack_i = 1'b1; mem_rdata_i = 16'hA5A5;
    tick();
    mem_ack_i = 1'b0;
    chk("dl_ack",  32'(ack_o), 32'b01);
    chk("dl_err",  32'(err_o), 0);
    chk("dl_rd",   32'(rdata_o), 32'hA5A5);
    chk("dl_tcnt", 32'(timeout_cnt_o), 1);
    req_i[0] = 1'b0;
    tick();

    // ---- reset in the middle of BUSY, off the clock edge
    req_i[0] = 1'b1; addr_i[0] = 24'h000300;
    tick(); tick();
    chk("mr_busy_pre", 32'(busy_o), 1);
    #3 arst_n_i = 1'b0;
    #1;
    chk_zero("mr");
    req_i = 2'b10; addr_i[1] = 24'h0000B1; we_i = '0;
    @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    tick();
    chk("mr_mreq", 32'(mem_req_o), 1);
    chk("mr_gnt",  32'(mem_addr_o), 32'h0000B1);
    mem_ack_i = 1'b1; mem_rdata_i = 16'h0B0B;
    tick();
    mem_ack_i = 1'b0;
    chk("mr_ack", 32'(ack_o), 32'b10);
    req_i = '0;
    tick();

    // ---- round-robin: both requesting from reset, memory acks at once
    arst_n_i = 1'b0;
    req_i = 2'b11; we_i = '0; addr_i[0] = 24'h000010; addr_i[1] = 24'h000011;
    mem_ack_i = 1'b1; mem_rdata_i = 16'h3C3C;
    @(posedge clk_i);
    #1 arst_n_i = 1'b1;
    last = 0; ngr = 0; exp_g = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (mem_req_o) begin
        chk("rr_gnt", 32'(mem_addr_o), 32'h10 + 32'(exp_g));
        chk("rr_gap", 32'(c - last), ngr == 0 ? 32'd1 : 32'd3);
        last  = c;
        exp_g = exp_g ^ 1;
        ngr++;
      end
    end
    chk("rr_cnt", 32'(ngr), 7);
    req_i = '0; mem_ack_i = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
